// File: rtl/wb_stage_ext_if.sv
// Writeback-stage bus: MEM/WB pipeline inputs and the register-file write port.
interface wb_stage_ext_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  stall;
    logic                  wb_reg_write;
    logic [1:0]            wb_sel;
    logic [2:0]            ld_type;
    logic [1:0]            byte_off;
    logic [31:0]           read_data;
    logic [31:0]           alu_result;
    logic [31:0]           link_pc;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_register;
    logic [31:0]           write_data_reg;

    // Pipeline side: drives the instruction, observes the register-file port.
    modport master (
        output in_valid, stall, wb_reg_write, wb_sel, ld_type, byte_off,
               read_data, alu_result, link_pc, dest_reg,
        input  reg_write, write_register, write_data_reg
    );

    // Writeback stage side.
    modport slave (
        input  in_valid, stall, wb_reg_write, wb_sel, ld_type, byte_off,
               read_data, alu_result, link_pc, dest_reg,
        output reg_write, write_register, write_data_reg
    );
endinterface

// File: rtl/wb_stage_ext.sv
// MIPS writeback stage: result select, sub-word load alignment, registered
// register-file write port, retired-instruction counter and misalign debug flag.
module wb_stage_ext #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned CNT_W       = 32,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter bit          ZERO_REG_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_stage_ext_if.slave         bus,
    output logic [CNT_W-1:0]      retired_count,
    output logic                  misalign_err,
    output logic [REG_ADDR_W-1:0] misalign_reg
);
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_type_e;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_MEM  = 2'd1,
        SEL_LINK = 2'd2
    } wb_sel_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        accept;
    logic        mis;
    logic        is_mem;
    logic        to_zero;
    logic        wr_en_next;
    logic [1:0]  lane;
    logic        half;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] sel_data;

    // Lane selection, load extension, misalignment and write-enable decode.
    always_comb begin
        accept   = bus.in_valid & ~bus.stall;
        is_mem   = (bus.wb_sel == SEL_MEM);
        lane     = BIG_ENDIAN ? ~bus.byte_off : bus.byte_off;
        half     = BIG_ENDIAN ? ~bus.byte_off[1] : bus.byte_off[1];
        ld_byte  = bus.read_data[{lane, 3'b000} +: 8];
        ld_half  = bus.read_data[{half, 4'b0000} +: 16];
        ld_data  = bus.read_data;
        mis      = 1'b0;
        case (bus.ld_type)
            LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   ld_data = {24'h0, ld_byte};
            LD_H: begin
                ld_data = {{16{ld_half[15]}}, ld_half};
                mis     = bus.byte_off[0];
            end
            LD_HU: begin
                ld_data = {16'h0, ld_half};
                mis     = bus.byte_off[0];
            end
            default: mis = (bus.byte_off != 2'b00);
        endcase
        mis = mis & is_mem;

        case (bus.wb_sel)
            SEL_MEM:  sel_data = ld_data;
            SEL_LINK: sel_data = bus.link_pc;
            default:  sel_data = bus.alu_result;
        endcase

        to_zero    = ZERO_REG_EN && (bus.dest_reg == '0);
        wr_en_next = bus.wb_reg_write & ~mis & ~to_zero;
    end

    // Output register: update on accept, otherwise drop the write enable and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.reg_write      <= 1'b0;
            bus.write_register <= '0;
            bus.write_data_reg <= '0;
            retired_count      <= '0;
            misalign_err       <= 1'b0;
            misalign_reg       <= '0;
        end else if (accept) begin
            bus.reg_write      <= wr_en_next;
            bus.write_register <= bus.dest_reg;
            bus.write_data_reg <= sel_data;
            retired_count      <= retired_count + CNT_ONE;
            if (mis && !misalign_err) begin
                misalign_err <= 1'b1;
                misalign_reg <= bus.dest_reg;
            end
        end else begin
            bus.reg_write <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_stage_ext.sv
// Directed bench for wb_stage_ext (default parameters plus a CNT_W=4 instance).
module tb_wb_stage_ext;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    wb_stage_ext_if #(.REG_ADDR_W(5)) ifc ();
    wb_stage_ext_if #(.REG_ADDR_W(5)) ifc4 ();

    logic [31:0] cnt;
    logic [3:0]  cnt4;
    logic        merr, merr4;
    logic [4:0]  mreg, mreg4;

    wb_stage_ext #(.REG_ADDR_W(5), .CNT_W(32), .BIG_ENDIAN(1'b1), .ZERO_REG_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(ifc),
        .retired_count(cnt), .misalign_err(merr), .misalign_reg(mreg)
    );

    wb_stage_ext #(.REG_ADDR_W(5), .CNT_W(4), .BIG_ENDIAN(1'b1), .ZERO_REG_EN(1'b1)) dut4 (
        .clk(clk), .rst(rst), .bus(ifc4),
        .retired_count(cnt4), .misalign_err(merr4), .misalign_reg(mreg4)
    );

    assign ifc4.in_valid     = ifc.in_valid;
    assign ifc4.stall        = ifc.stall;
    assign ifc4.wb_reg_write = ifc.wb_reg_write;
    assign ifc4.wb_sel       = ifc.wb_sel;
    assign ifc4.ld_type      = ifc.ld_type;
    assign ifc4.byte_off     = ifc.byte_off;
    assign ifc4.read_data    = ifc.read_data;
    assign ifc4.alu_result   = ifc.alu_result;
    assign ifc4.link_pc      = ifc.link_pc;
    assign ifc4.dest_reg     = ifc.dest_reg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic drive(input logic v, input logic st, input logic wr, input logic [1:0] sel,
                         input logic [2:0] ld, input logic [1:0] off, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [31:0] lpc, input logic [4:0] dst);
        ifc.in_valid     = v;
        ifc.stall        = st;
        ifc.wb_reg_write = wr;
        ifc.wb_sel       = sel;
        ifc.ld_type      = ld;
        ifc.byte_off     = off;
        ifc.read_data    = rd;
        ifc.alu_result   = alu;
        ifc.link_pc      = lpc;
        ifc.dest_reg     = dst;
    endtask

    // One active edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string tag, input logic rw, input logic [4:0] wr,
                              input logic [31:0] wd, input logic [31:0] c);
        check({tag, ".reg_write"}, {31'b0, ifc.reg_write}, {31'b0, rw});
        check({tag, ".write_register"}, {27'b0, ifc.write_register}, {27'b0, wr});
        check({tag, ".write_data_reg"}, ifc.write_data_reg, wd);
        check({tag, ".retired_count"}, cnt, c);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
        rst = 1'b1;
        step();
        step();
        check_port("reset", 1'b0, 5'd0, 32'h0, 32'd0);
        check("reset.misalign_err", {31'b0, merr}, 32'd0);
        check("reset.misalign_reg", {27'b0, mreg}, 32'd0);
        rst = 1'b0;

        // ALU op
        drive(1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 32'h0, 32'h12345678, 32'h0, 5'd8);
        step();
        check_port("alu", 1'b1, 5'd8, 32'h12345678, 32'd1);

        // Big-endian sub-word loads
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 2'd0, 32'h80FF7F01, 32'h0, 32'h0, 5'd1);
        step();
        check_port("lb0", 1'b1, 5'd1, 32'hFFFFFF80, 32'd2);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd2, 2'd1, 32'h80FF7F01, 32'h0, 32'h0, 5'd2);
        step();
        check_port("lbu1", 1'b1, 5'd2, 32'h000000FF, 32'd3);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd3, 2'd2, 32'h80FF7F01, 32'h0, 32'h0, 5'd3);
        step();
        check_port("lh2", 1'b1, 5'd3, 32'h00007F01, 32'd4);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd4, 2'd0, 32'h80FF7F01, 32'h0, 32'h0, 5'd6);
        step();
        check_port("lhu0", 1'b1, 5'd6, 32'h000080FF, 32'd5);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 2'd3, 32'h80FF7F01, 32'h0, 32'h0, 5'd7);
        step();
        check_port("lb3", 1'b1, 5'd7, 32'h00000001, 32'd6);

        // Stall: one write, then three frozen cycles with a new instruction waiting
        drive(1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0000A5A5, 32'h0, 5'd5);
        step();
        check_port("stall.pre", 1'b1, 5'd5, 32'h0000A5A5, 32'd7);
        drive(1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0000BEEF, 32'h0, 5'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            check_port("stall.hold", 1'b0, 5'd5, 32'h0000A5A5, 32'd7);
        end
        ifc.stall = 1'b0;
        step();
        check_port("stall.release", 1'b1, 5'd10, 32'h0000BEEF, 32'd8);

        // Misaligned loads: first one captured, second leaves capture alone
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd0, 2'd2, 32'h11223344, 32'h0, 32'h0, 5'd9);
        step();
        check("mis1.reg_write", {31'b0, ifc.reg_write}, 32'd0);
        check("mis1.misalign_err", {31'b0, merr}, 32'd1);
        check("mis1.misalign_reg", {27'b0, mreg}, 32'd9);
        check("mis1.retired_count", cnt, 32'd9);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd3, 2'd1, 32'h11223344, 32'h0, 32'h0, 5'd4);
        step();
        check("mis2.reg_write", {31'b0, ifc.reg_write}, 32'd0);
        check("mis2.write_register", {27'b0, ifc.write_register}, 32'd4);
        check("mis2.misalign_err", {31'b0, merr}, 32'd1);
        check("mis2.misalign_reg", {27'b0, mreg}, 32'd9);
        check("mis2.retired_count", cnt, 32'd10);

        // JAL link write
        drive(1'b1, 1'b0, 1'b1, 2'd2, 3'd0, 2'd0, 32'h0, 32'h0000DEAD, 32'h00400010, 5'd31);
        step();
        check_port("jal", 1'b1, 5'd31, 32'h00400010, 32'd11);

        // Write to $0 dropped but retired
        drive(1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 32'h0, 32'h00000055, 32'h0, 5'd0);
        step();
        check_port("zero", 1'b0, 5'd0, 32'h00000055, 32'd12);

        // Bubble: nothing accepted
        ifc.in_valid = 1'b0;
        step();
        check_port("bubble", 1'b0, 5'd0, 32'h00000055, 32'd12);

        // Reserved wb_sel and unknown ld_type fall back to ALU and LW
        drive(1'b1, 1'b0, 1'b1, 2'd3, 3'd0, 2'd0, 32'h00000011, 32'h00000077, 32'h0, 5'd12);
        step();
        check_port("sel3", 1'b1, 5'd12, 32'h00000077, 32'd13);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd5, 2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 5'd13);
        step();
        check_port("ld5", 1'b1, 5'd13, 32'hCAFEF00D, 32'd14);

        // Reset while an accept is presented: reset wins
        rst = 1'b1;
        step();
        check_port("rst_accept", 1'b0, 5'd0, 32'h0, 32'd0);
        check("rst_accept.misalign_err", {31'b0, merr}, 32'd0);
        check("rst_accept.misalign_reg", {27'b0, mreg}, 32'd0);
        check("rst_accept.cnt4", {28'b0, cnt4}, 32'd0);
        rst = 1'b0;

        // Narrow counter wraps: 17 accepts -> 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 32'h0, 32'h100 + i, 32'h0, 5'd1 + 5'(i % 8));
            step();
        end
        check("wrap.cnt4", {28'b0, cnt4}, 32'd1);
        check("wrap.cnt32", cnt, 32'd17);
        check("wrap.write_data_reg", ifc.write_data_reg, 32'h00000110);

        // Mid-stream reset during a stall with a pending misalignment set
        drive(1'b1, 1'b0, 1'b1, 2'd1, 3'd0, 2'd1, 32'h0, 32'h0, 32'h0, 5'd20);
        step();
        check("pre_rst.misalign_reg", {27'b0, mreg}, 32'd20);
        ifc.stall = 1'b1;
        rst = 1'b1;
        step();
        check_port("rst_mid", 1'b0, 5'd0, 32'h0, 32'd0);
        check("rst_mid.misalign_err", {31'b0, merr}, 32'd0);
        check("rst_mid.cnt4", {28'b0, cnt4}, 32'd0);
        check("rst_mid.reg_write4", {31'b0, ifc4.reg_write}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
